piece_drop: RTL

PIECE_DROP -- requirements
Module: piece_drop

---
 rtl/piece_drop.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/piece_drop.sv
// Gravity stage of a 8x4 falling-block board: spawns a piece, applies lateral moves and
// timed one-row drops, then merges the piece into the board and flags full rows.
module piece_drop #(
  parameter int unsigned DROP_TICKS = 8
) (
  input  logic        clka,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  curr_piece,
  input  logic [31:0] board_in,
  input  logic        move_left,
  input  logic        move_right,
  output logic [31:0] board_out,
  output logic [31:0] active_mask,
  output logic        which_row,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    StIdle,
    StFall,
    StLock,
    StDone,
    StOver
  } state_e;

  localparam logic [7:0]  TermCnt = 8'(DROP_TICKS - 1);
  localparam logic [31:0] Col0    = 32'h1111_1111;
  localparam logic [31:0] Col3    = 32'h8888_8888;
  localparam logic [31:0] Row7    = 32'hF000_0000;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] board_q, board_d;
  logic [31:0] board_out_q, board_out_d;
  logic [31:0] mask_q, mask_d;
  logic        which_row_q, which_row_d;
  logic        error_q, error_d;

  logic [31:0] spawn_mask;
  logic [31:0] merged;
  logic [31:0] left_mask;
  logic [31:0] right_mask;
  logic [31:0] down_mask;
  logic        any_full;

  always_comb begin
    spawn_mask = 32'h0;
    unique case (curr_piece)
      2'b00: spawn_mask = 32'h0000_0002;
      2'b01: spawn_mask = 32'h0000_0006;
      2'b10: spawn_mask = 32'h0000_0066;
      2'b11: spawn_mask = 32'h0000_0062;
      default: spawn_mask = 32'h0;
    endcase
  end

  // Candidate positions; a shift is only taken when no cell leaves the board.
  assign left_mask  = mask_q >> 1;
  assign right_mask = mask_q << 1;
  assign down_mask  = mask_q << 4;
  assign merged     = board_q | mask_q;

  always_comb begin
    any_full = 1'b0;
    for (int r = 0; r < 8; r++) begin
      if (merged[4*r +: 4] == 4'hF) begin
        any_full = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    board_d     = board_q;
    board_out_d = board_out_q;
    mask_d      = mask_q;
    which_row_d = which_row_q;
    error_d     = error_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          board_d = board_in;
          if ((spawn_mask & board_in) != 32'h0) begin
            error_d = 1'b1;
            state_d = StOver;
          end else begin
            mask_d  = spawn_mask;
            cnt_d   = 8'h0;
            state_d = StFall;
          end
        end
      end

      StFall: begin
        if (cnt_q == TermCnt) begin
          cnt_d = 8'h0;
          if (((mask_q & Row7) == 32'h0) && ((down_mask & board_q) == 32'h0)) begin
            mask_d = down_mask;
          end else begin
            state_d = StLock;
          end
        end else begin
          cnt_d = cnt_q + 8'h1;
          if (move_left && !move_right) begin
            if (((mask_q & Col0) == 32'h0) && ((left_mask & board_q) == 32'h0)) begin
              mask_d = left_mask;
            end
          end else if (move_right && !move_left) begin
            if (((mask_q & Col3) == 32'h0) && ((right_mask & board_q) == 32'h0)) begin
              mask_d = right_mask;
            end
          end
        end
      end

      StLock: begin
        board_out_d = merged;
        which_row_d = any_full;
        mask_d      = 32'h0;
        state_d     = StDone;
      end

      StDone: begin
        state_d = StIdle;
      end

      StOver: begin
        state_d = StOver;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 8'h0;
      board_q     <= 32'h0;
      board_out_q <= 32'h0;
      mask_q      <= 32'h0;
      which_row_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      board_q     <= board_d;
      board_out_q <= board_out_d;
      mask_q      <= mask_d;
      which_row_q <= which_row_d;
      error_q     <= error_d;
    end
  end

  assign board_out   = board_out_q;
  assign active_mask = mask_q;
  assign which_row   = which_row_q;
  assign error       = error_q;
  assign busy        = (state_q == StFall) || (state_q == StLock);
  assign done        = (state_q == StDone);

endmodule
